// File: rtl/ball_pkg.sv
// Shared types for the ball position engine: FSM states and direction encoding.
package ball_pkg;

  typedef enum logic {
    MOVING = 1'b0,
    LOST   = 1'b1
  } state_t;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/axis_stepper.sv
// One axis of ball motion: holds position/direction, steps by speed with clamp and wall reflection.
// Position/direction are registered; hit/hit_max describe the tick being applied this cycle.
module axis_stepper
  import ball_pkg::*;
#(
  parameter int   W        = 10,
  parameter int   STEP_W   = 3,
  parameter int   MIN      = 0,
  parameter int   MAX      = 636,
  parameter int   INIT     = 318,
  parameter logic DIR_INIT = DIR_POS
) (
  input  logic              clk,
  input  logic              init,
  input  logic              freeze,
  input  logic              step,
  input  logic [STEP_W-1:0] speed,
  input  logic              bounce,
  output logic [W-1:0]      pos,
  output logic              dir,
  output logic              hit,
  output logic              hit_max
);

  localparam logic [W:0] MIN_E = (W+1)'(MIN);
  localparam logic [W:0] MAX_E = (W+1)'(MAX);

  logic       dir_eff;
  logic       moving;
  logic       hit_min;
  logic [W:0] spd_e;
  logic [W:0] sum;
  logic [W:0] diff;

  assign dir_eff = dir ^ bounce;
  assign spd_e   = (W+1)'(speed);
  // One extra bit so overshoot and borrow are visible instead of wrapping.
  assign sum     = {1'b0, pos} + spd_e;
  assign diff    = {1'b0, pos} - spd_e;
  assign moving  = step && (speed != '0);
  assign hit_max = moving && dir_eff && (sum >= MAX_E);
  assign hit_min = moving && !dir_eff && (diff[W] || (diff <= MIN_E));
  assign hit     = hit_max | hit_min;

  always_ff @(posedge clk) begin
    if (init) begin
      pos <= W'(INIT);
      dir <= DIR_INIT;
    end else if (!freeze) begin
      if (hit_max) begin
        pos <= MAX_E[W-1:0];
        dir <= DIR_NEG;
      end else if (hit_min) begin
        pos <= MIN_E[W-1:0];
        dir <= DIR_POS;
      end else begin
        if (moving) begin
          pos <= dir_eff ? sum[W-1:0] : diff[W-1:0];
        end
        dir <= dir_eff;
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Ball position engine: two axis steppers, wall_hit merge, optional floor-loss FSM.
// Optional feature macro: BALL_FLOOR_LOSS_EN (bottom edge loses the ball instead of reflecting).
module ball_motion
  import ball_pkg::*;
#(
  parameter int X_W    = 10,
  parameter int Y_W    = 10,
  parameter int STEP_W = 3,
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 636,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = 476,
  parameter int X_INIT = 318,
  parameter int Y_INIT = 400
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [STEP_W-1:0] speed_x,
  input  logic [STEP_W-1:0] speed_y,
  input  logic              bounce_x,
  input  logic              bounce_y,
  input  logic              serve,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              x_dir,
  output logic              y_dir,
  output logic              wall_hit,
  output logic              lost
);

  logic init;
  logic freeze;
  logic tick;
  logic hit_x, hit_max_x;
  logic hit_y, hit_max_y;

  assign tick = enable && !freeze;

  axis_stepper #(
    .W(X_W), .STEP_W(STEP_W), .MIN(X_MIN), .MAX(X_MAX), .INIT(X_INIT), .DIR_INIT(DIR_POS)
  ) u_x (
    .clk(clk), .init(init), .freeze(freeze), .step(tick), .speed(speed_x),
    .bounce(bounce_x), .pos(x), .dir(x_dir), .hit(hit_x), .hit_max(hit_max_x)
  );

  axis_stepper #(
    .W(Y_W), .STEP_W(STEP_W), .MIN(Y_MIN), .MAX(Y_MAX), .INIT(Y_INIT), .DIR_INIT(DIR_NEG)
  ) u_y (
    .clk(clk), .init(init), .freeze(freeze), .step(tick), .speed(speed_y),
    .bounce(bounce_y), .pos(y), .dir(y_dir), .hit(hit_y), .hit_max(hit_max_y)
  );

`ifdef BALL_FLOOR_LOSS_EN
  state_t state;
  logic   unused_hit_max_x;

  assign unused_hit_max_x = hit_max_x;
  assign freeze = (state == LOST);
  assign init   = !resetn || (freeze && serve);

  // Reaching the floor is a loss, not a reflection, so it never pulses wall_hit.
  always_ff @(posedge clk) begin
    if (init) begin
      state    <= MOVING;
      lost     <= 1'b0;
      wall_hit <= 1'b0;
    end else if (state == MOVING) begin
      wall_hit <= hit_x || (hit_y && !hit_max_y);
      if (hit_max_y) begin
        state <= LOST;
        lost  <= 1'b1;
      end
    end else begin
      wall_hit <= 1'b0;
    end
  end
`else
  logic unused_in;

  assign unused_in = serve ^ hit_max_x ^ hit_max_y;
  assign freeze    = 1'b0;
  assign init      = !resetn;
  assign lost      = 1'b0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wall_hit <= 1'b0;
    end else begin
      wall_hit <= hit_x || hit_y;
    end
  end
`endif

endmodule

// File: tb/tb_ball_motion.sv
// Directed self-checking bench for ball_motion; floor behaviour follows BALL_FLOOR_LOSS_EN.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] speed_x = '0;
  logic [2:0] speed_y = '0;
  logic       bounce_x = 1'b0;
  logic       bounce_y = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] x;
  logic [9:0] y;
  logic       x_dir, y_dir, wall_hit, lost;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ball_motion dut (
    .clk(clk), .resetn(resetn), .enable(enable), .speed_x(speed_x), .speed_y(speed_y),
    .bounce_x(bounce_x), .bounce_y(bounce_y), .serve(serve),
    .x(x), .y(y), .x_dir(x_dir), .y_dir(y_dir), .wall_hit(wall_hit), .lost(lost)
  );

  // Drive inputs for one posedge; outputs are settled when this returns (next negedge).
  task automatic apply(input logic en, input logic [2:0] sx, input logic [2:0] sy,
                       input logic bx, input logic by);
    enable = en; speed_x = sx; speed_y = sy; bounce_x = bx; bounce_y = by;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [2:0] sx, input logic [2:0] sy);
    for (int i = 0; i < n; i++) apply(1'b1, sx, sy, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    apply(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    apply(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    tests++;
    if ({x, y, x_dir, y_dir, wall_hit, lost} !== {10'd318, 10'd400, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset: x=%0d y=%0d xd=%0b yd=%0b wh=%0b lost=%0b", x, y, x_dir, y_dir, wall_hit, lost);
    end
    resetn = 1'b1;
  endtask

  task automatic test_first_tick;
    apply(1'b1, 3'd3, 3'd2, 1'b0, 1'b0);
    chk("first_x", x, 321);
    chk("first_y", y, 398);
    chk("first_wh", wall_hit, 0);
  endtask

  task automatic test_right_wall;
    // 321 + 44*7 = 629, +5 -> 634
    run(44, 3'd7, 3'd0);
    apply(1'b1, 3'd5, 3'd0, 1'b0, 1'b0);
    chk("pre_right_x", x, 634);
    apply(1'b1, 3'd4, 3'd0, 1'b0, 1'b0);
    chk("right_x", x, 636);
    chk("right_dir", x_dir, 0);
    chk("right_wh", wall_hit, 1);
    apply(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("right_wh_one_cycle", wall_hit, 0);
    chk("right_hold_x", x, 636);
  endtask

  task automatic test_left_underflow;
    // 636 - 90*7 = 6, -4 -> 2
    run(90, 3'd7, 3'd0);
    apply(1'b1, 3'd4, 3'd0, 1'b0, 1'b0);
    chk("pre_left_x", x, 2);
    chk("pre_left_wh", wall_hit, 0);
    apply(1'b1, 3'd5, 3'd0, 1'b0, 1'b0);
    chk("left_x", x, 0);
    chk("left_dir", x_dir, 1);
    chk("left_wh", wall_hit, 1);
  endtask

  task automatic test_bounce;
    // 0 + 14*7 = 98, +2 -> 100
    run(14, 3'd7, 3'd0);
    apply(1'b1, 3'd2, 3'd0, 1'b0, 1'b0);
    chk("pre_bounce_x", x, 100);
    apply(1'b1, 3'd2, 3'd0, 1'b1, 1'b0);
    chk("bounce_x", x, 98);
    chk("bounce_dir", x_dir, 0);
    chk("bounce_wh", wall_hit, 0);
    apply(1'b0, 3'd2, 3'd0, 1'b1, 1'b0);
    chk("bounce_noen_x", x, 98);
    chk("bounce_noen_dir", x_dir, 1);
    // 98 + 76*7 = 630, +6 lands exactly on the bound
    run(76, 3'd7, 3'd0);
    apply(1'b1, 3'd6, 3'd0, 1'b0, 1'b0);
    chk("exact_max_x", x, 636);
    chk("exact_max_wh", wall_hit, 1);
    apply(1'b1, 3'd1, 3'd0, 1'b0, 1'b0);
    chk("x635", x, 635);
    chk("x635_dir", x_dir, 0);
    apply(1'b1, 3'd2, 3'd0, 1'b1, 1'b0);
    chk("bounce_wall_x", x, 636);
    chk("bounce_wall_dir", x_dir, 0);
    chk("bounce_wall_wh", wall_hit, 1);
  endtask

  task automatic test_zero_speed;
    apply(1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("zero_x", x, 636);
    chk("zero_y", y, 398);
    chk("zero_wh", wall_hit, 0);
  endtask

  task automatic test_floor;
    apply(1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    chk("floor_ydir", y_dir, 1);
    // 398 + 11*7 = 475
    run(11, 3'd0, 3'd7);
    chk("pre_floor_y", y, 475);
    apply(1'b1, 3'd0, 3'd3, 1'b0, 1'b0);
    chk("floor_y", y, 476);
`ifdef BALL_FLOOR_LOSS_EN
    chk("floor_lost", lost, 1);
    chk("floor_wh", wall_hit, 0);
    apply(1'b1, 3'd5, 3'd5, 1'b1, 1'b1);
    apply(1'b1, 3'd5, 3'd5, 1'b0, 1'b0);
    chk("frozen_x", x, 636);
    chk("frozen_y", y, 476);
    chk("frozen_lost", lost, 1);
    serve = 1'b1;
    apply(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    serve = 1'b0;
    chk("serve_x", x, 318);
    chk("serve_y", y, 400);
    chk("serve_lost", lost, 0);
    chk("serve_xdir", x_dir, 1);
`else
    chk("floor_ydir_out", y_dir, 0);
    chk("floor_wh", wall_hit, 1);
    chk("floor_lost", lost, 0);
`endif
    apply(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_on_hit;
    test_reset();
    // 318 + 45*7 = 633; +4 would reflect
    run(45, 3'd7, 3'd0);
    chk("pre_rst_x", x, 633);
    resetn = 1'b0;
    apply(1'b1, 3'd4, 3'd0, 1'b0, 1'b0);
    resetn = 1'b1;
    chk("rst_hit_x", x, 318);
    chk("rst_hit_y", y, 400);
    chk("rst_hit_dir", x_dir, 1);
    chk("rst_hit_wh", wall_hit, 0);
    apply(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_tick();
    test_right_wall();
    test_left_underflow();
    test_bounce();
    test_zero_speed();
    test_floor();
    test_reset_on_hit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ball_motion.md
# ball_motion

Parametrised ball position engine for the brick-breaker datapath; the successor to the fixed 10-bit up/down position counters. Each move tick it advances the ball by a programmable per-axis speed, clamps it to the playfield and reflects it at the walls. It accepts external bounce requests from the paddle/brick collision logic. It sits between the game-control FSM (which supplies `enable` ticks and bounce requests) and the renderer (which consumes `x`/`y`).

## Interface
- `X_W`, 10: x position width (bits)
- `Y_W`, 10: y position width (bits)
- `STEP_W`, 3: speed field width per axis
- `X_MIN`, 0: leftmost legal x
- `X_MAX`, 636: rightmost legal x (ball top-left corner)
- `Y_MIN`, 0: topmost legal y
- `Y_MAX`, 476: bottommost legal y
- `X_INIT`, 318: x after reset/serve
- `Y_INIT`, 400: y after reset/serve

Ports:
- `clk` in 1: system clock; single clock domain.
- `resetn` in 1: synchronous, active-low reset.
- `enable` in 1: move tick; one step per cycle high.
- `speed_x` in `STEP_W`: x pixels per tick.
- `speed_y` in `STEP_W`: y pixels per tick.
- `bounce_x` in 1: external request to reverse x direction.
- `bounce_y` in 1: external request to reverse y direction.
- `serve` in 1: relaunch after loss (macro-dependent).
- `x` out `X_W`: registered x position.
- `y` out `Y_W`: registered y position.
- `x_dir` out 1: 1 = increasing x (right).
- `y_dir` out 1: 1 = increasing y (down).
- `wall_hit` out 1: one-cycle pulse on any wall reflection.
- `lost` out 1: ball has left through the bottom edge (macro-dependent).

## Operation
- Reset (`resetn`=0 at posedge): x=`X_INIT`, y=`Y_INIT`, x_dir=1, y_dir=0, wall_hit=0, lost=0, state MOVING. Reset overrides every other input.
- Effective direction each cycle: `dir_eff = dir ^ bounce`. The bounce is applied whether or not `enable` is high; with `enable`=0 only the dir register flips.
- On `enable` in MOVING, per axis, next = pos ± speed computed in width+1 bits (no wrap-around):
  - moving +, next ≥ MAX: pos=MAX, dir=0, wall_hit=1.
  - moving −, next ≤ MIN (including borrow/underflow): pos=MIN, dir=1, wall_hit=1.
  - otherwise pos=next, dir=dir_eff.
- A wall reflection sets dir absolutely, not by toggle, so a wall hit beats a simultaneous external bounce.
- speed=0 on an axis: position and dir_eff are held and no wall_hit is raised for that axis, even when the ball sits at a bound.
- Both axes hitting in the same tick (corner): both reflect; wall_hit is a single pulse.
- Legality: X_MIN < X_MAX; the maximum speed must be ≤ X_MAX−X_MIN (same for y). Out-of-range inputs need not be handled.

## Timing
- All outputs are registered. Position and direction update on the posedge at which `enable` is sampled high, so they are visible one cycle after the tick.
- wall_hit is high for exactly the cycle following the reflecting tick and is 0 otherwise.
- bounce_x/bounce_y are level-sampled each cycle. Holding one high for N cycles toggles direction N times; the control FSM must pulse them.
- serve is acted on only in state LOST; it takes effect on the next posedge.

## Configuration
- `BALL_FLOOR_LOSS_EN` defined:
  - A tick that would reach y ≥ Y_MAX while moving down sets y=Y_MAX and lost=1, moves the block to state LOST, and raises no wall_hit.
  - In LOST, enable and bounces are ignored and the position freezes.
  - serve=1 in LOST restores the reset values (lost=0, MOVING).
- Not defined: the bottom edge reflects like the other walls. lost is tied to 0, serve is ignored, and the LOST state does not exist.

## Structure
- Shared package `ball_pkg`: state enum (MOVING, LOST), direction constants DIR_POS=1/DIR_NEG=0.
- Sub-module `axis_stepper`, parametrised by width/MIN/MAX/INIT. It holds pos and dir for one axis, performs the width+1 add/sub and clamp/reflect, and reports a hit flag plus a hit_max flag. It is instantiated once for x and once for y.
- The top level holds the LOST FSM, wall_hit merging and the serve/reset muxing.

## Test plan
- Reset, then enable with speed_x=3, speed_y=2 for one tick → x=321, y=398, wall_hit=0.
- x=634, x_dir=1, speed_x=4, one tick → x=636, x_dir=0, wall_hit pulse for one cycle.
- x=2, x_dir=0, speed_x=5 (underflow) → x=0, x_dir=1, wall_hit=1.
- bounce_x=1 together with enable at x=100, x_dir=1, speed 2 → x=98, x_dir=0. bounce_x=1 at x=635, x_dir=0, speed 2 → x=636, x_dir=0, wall_hit=1.
- With `BALL_FLOOR_LOSS_EN`: y=475, y_dir=1, speed_y=3 → y=476, lost=1. Further enables leave x/y unchanged; serve → x=318, y=400, lost=0. Without the macro, the same stimulus → y=476, y_dir=0, wall_hit=1.
- Assert resetn=0 during a reflecting tick → the next state is the reset values and wall_hit=0.
